fsic_io_serdes_rx_deframer: RTL and testbench
=============================================

# fsic_io_serdes_rx_deframer

Core-side consumer of the RX serdes nibble stream. It runs in the `coreclk` domain and takes one `pCLK_RATIO`-bit nibble per cycle while `rxdata_in_valid` is high. It finds start-of-frame nibbles, assembles the following data nibbles LSB-first into `pDATA_WIDTH`-bit words, and queues the words in a small FIFO. The FIFO drains through an AXI-Stream master toward the FSIC axis switch; link errors and overflows are reported through sticky status.

## Interface
- `pCLK_RATIO`, 4: nibble width; equals the RX serdes output width.
- `pDATA_WIDTH`, 32: assembled word width; must be a multiple of `pCLK_RATIO`.
- `pOUT_DEPTH`, 4: output FIFO depth in words; power of two, ≥2.
- `pSOF`, 4'hA: start-of-frame nibble code.
- `pIDLE`, 4'h0: idle nibble code.
- `coreclk` input 1: single clock, all logic on the rising edge.
- `axis_rst_n` input 1: asynchronous, active-low reset.
- `rx_en` input 1: deframer enable; low synchronously flushes the FSM and assembly state; the FIFO is kept.
- `rxdata_in` input `pCLK_RATIO`: nibble from the RX serdes.
- `rxdata_in_valid` input 1: nibble valid; once high it stays high in normal operation.
- `m_tdata` output `pDATA_WIDTH`: output word.
- `m_tvalid` output 1: FIFO not empty.
- `m_tready` input 1: downstream ready.
- `err_clr` input 1: synchronous clear of the sticky status.
- `frm_err` output 1: sticky; set when a nibble that is neither `pSOF` nor `pIDLE` arrives in HUNT.
- `ovf_err` output 1: sticky; set when a word is dropped because the FIFO is full.
- `frm_err_cnt` output 8: saturating count of framing errors.

## Operation
- A nibble is consumed at every rising edge where `rx_en && rxdata_in_valid`. With no nibble consumed, the FSM, counter and shift register hold.
- FSM states:
  - **HUNT.** `pSOF` → DATA with `nib_cnt`=0. `pIDLE` → stay in HUNT. Any other code → stay in HUNT, set `frm_err`, increment `frm_err_cnt` (saturates at 255).
  - **DATA.** Shift the nibble into `word_sr[pDATA_WIDTH-1 -: pCLK_RATIO]`; older bits shift right, so the first nibble lands in `[3:0]`. Increment `nib_cnt`.
  - On the last nibble (`nib_cnt == pDATA_WIDTH/pCLK_RATIO-1`), push `{nibble, word_sr[pDATA_WIDTH-1:pCLK_RATIO]}` to the FIFO and return to HUNT. Frames are therefore 1 + 8 nibbles at the defaults.
- Nibbles inside DATA are never checked against `pSOF`/`pIDLE`; a data nibble equal to `pSOF` is plain data.
- Back-to-back frames are legal: a `pSOF` may arrive in the cycle right after the last data nibble.
- FIFO behaviour:
  - Push when not full, or when full with a pop in the same cycle.
  - Otherwise the word is dropped, `ovf_err` is set and the FIFO contents are unchanged.
  - Pop on `m_tvalid && m_tready`.
- `err_clr` clears `frm_err`, `ovf_err` and `frm_err_cnt`. If a new error event occurs in the same cycle, the set wins and the count becomes 1.
- `rx_en` low: FSM → HUNT, `nib_cnt`=0, `word_sr`=0; a partial word is discarded with no error flagged. The FIFO keeps draining.

## Timing
- Reset values: `m_tvalid`=0, `m_tdata`=0, `frm_err`=0, `ovf_err`=0, `frm_err_cnt`=0, FSM=HUNT, FIFO empty.
- The last data nibble is sampled at edge k; `m_tvalid`=1 and `m_tdata` valid from edge k onward, i.e. in cycle k+1. This is 1 cycle of latency.
- `m_tdata` is driven from the FIFO read pointer, with no extra register stage. It is stable while `m_tvalid && !m_tready` (AXI-S rule).
- `frm_err` and `frm_err_cnt` update at the same edge that samples the bad nibble. `ovf_err` updates at the edge of the dropped push.
- Sustained throughput is 1 word per 9 cycles at the defaults. With `m_tready` held high the FIFO never fills.
- `axis_rst_n` asserted mid-frame: every register returns to its reset value immediately (asynchronous). After release, the block starts in HUNT.

## Structure
- Shared package `fsic_serdes_pkg`: the `pSOF`/`pIDLE` codes, the FSM state encoding (HUNT, DATA), and the nibbles-per-word constant.
- One sub-module: `fsic_sync_fifo`, a single-clock FIFO with full/empty and a registered pointer count. It is reusable on the TX side.
- The FSM, shift register, counters and status logic live in the top module.

## Test plan
- **Reset and idle.** Reset, then 20 `pIDLE` nibbles → `m_tvalid`=0, `frm_err`=0.
- **Single frame.** `A,8,7,6,5,4,3,2,1` with `m_tready`=1 → one beat `m_tdata`=32'h12345678, `m_tvalid` high the cycle after the last nibble.
- **Back-to-back frames with stall.** 6 back-to-back frames with `m_tready`=0 → 4 words held and `ovf_err`=1 after the 5th frame. Then `m_tready`=1 → exactly the first 4 words come out, in order.
- **Framing error.** Nibble 3 in HUNT → `frm_err`=1, `frm_err_cnt`=1. A following valid frame is still captured. `err_clr` → all status back to 0.
- **Flush mid-frame.** Drop `rx_en` after 4 data nibbles, then send a full frame → only the new frame is output, no error flagged.
- **Pause and async reset.** Deassert `rxdata_in_valid` for 3 cycles mid-frame → word still correct. Assert `axis_rst_n` low mid-frame → all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/fsic_serdes_pkg.sv
// Shared definitions for the FSIC IO serdes nibble framing: line codes,
// deframer state encoding and word/nibble geometry.
package fsic_serdes_pkg;

  localparam int unsigned SERDES_NIB_W   = 4;
  localparam int unsigned SERDES_WORD_W  = 32;
  localparam logic [3:0]  SOF_CODE       = 4'hA;
  localparam logic [3:0]  IDLE_CODE      = 4'h0;

  typedef enum logic {
    ST_HUNT,
    ST_DATA
  } rx_state_e;

  function automatic int unsigned nibs_per_word(input int unsigned word_w,
                                                input int unsigned nib_w);
    return word_w / nib_w;
  endfunction

  localparam int unsigned NIBS_PER_WORD = nibs_per_word(SERDES_WORD_W, SERDES_NIB_W);

endpackage

// File: rtl/fsic_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; a write into a full
// FIFO is accepted only when a read retires an entry in the same cycle.
module fsic_sync_fifo #(
  parameter int unsigned pWIDTH = 32,
  parameter int unsigned pDEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [pWIDTH-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [pWIDTH-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(pDEPTH):0]    count
);

  localparam int unsigned AW = $clog2(pDEPTH);
  localparam int unsigned CW = AW + 1;

  logic [pWIDTH-1:0] mem [pDEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              do_wr;
  logic              do_rd;

  assign full    = (count == CW'(pDEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < pDEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) begin
        mem[wptr] <= wr_data;
        wptr      <= wptr + 1'b1;
      end
      if (do_rd) rptr <= rptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fsic_io_serdes_rx_deframer.sv
// RX serdes nibble deframer: hunts for SOF, assembles LSB-first words and
// queues them toward an AXI-Stream master, with sticky link/overflow status.
module fsic_io_serdes_rx_deframer
  import fsic_serdes_pkg::*;
#(
  parameter int unsigned           pCLK_RATIO  = SERDES_NIB_W,
  parameter int unsigned           pDATA_WIDTH = SERDES_WORD_W,
  parameter int unsigned           pOUT_DEPTH  = 4,
  parameter logic [pCLK_RATIO-1:0] pSOF        = SOF_CODE,
  parameter logic [pCLK_RATIO-1:0] pIDLE       = IDLE_CODE
) (
  input  logic                   coreclk,
  input  logic                   axis_rst_n,
  input  logic                   rx_en,
  input  logic [pCLK_RATIO-1:0]  rxdata_in,
  input  logic                   rxdata_in_valid,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  input  logic                   err_clr,
  output logic                   frm_err,
  output logic                   ovf_err,
  output logic [7:0]             frm_err_cnt
);

  localparam int unsigned NPW   = nibs_per_word(pDATA_WIDTH, pCLK_RATIO);
  localparam int unsigned CNT_W = (NPW > 1) ? $clog2(NPW) : 1;

  rx_state_e                        state;
  logic [CNT_W-1:0]                 nib_cnt;
  // Bits that would sit below the newest-but-seven nibble are never read,
  // so the shift register only keeps the upper pDATA_WIDTH-pCLK_RATIO bits.
  logic [pDATA_WIDTH-pCLK_RATIO-1:0] word_sr;
  logic [pDATA_WIDTH-1:0]           word_shifted;

  logic                   nib_take;
  logic                   last_nib;
  logic                   push_req;
  logic                   frm_evt;
  logic                   ovf_evt;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(pOUT_DEPTH):0] fifo_cnt;

  assign word_shifted = {rxdata_in, word_sr};
  assign nib_take     = rx_en && rxdata_in_valid;
  assign last_nib     = (nib_cnt == CNT_W'(NPW - 1));
  assign push_req     = nib_take && (state == ST_DATA) && last_nib;
  assign frm_evt      = nib_take && (state == ST_HUNT) &&
                        (rxdata_in != pSOF) && (rxdata_in != pIDLE);
  assign fifo_pop     = m_tready && !fifo_empty;
  assign ovf_evt      = push_req && fifo_full && !fifo_pop;
  assign m_tvalid     = (fifo_cnt != '0);

  always_ff @(posedge coreclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state   <= ST_HUNT;
      nib_cnt <= '0;
      word_sr <= '0;
    end else if (!rx_en) begin
      state   <= ST_HUNT;
      nib_cnt <= '0;
      word_sr <= '0;
    end else if (rxdata_in_valid) begin
      case (state)
        ST_HUNT: begin
          nib_cnt <= '0;
          if (rxdata_in == pSOF) state <= ST_DATA;
        end
        ST_DATA: begin
          word_sr <= word_shifted[pDATA_WIDTH-1:pCLK_RATIO];
          if (last_nib) begin
            state   <= ST_HUNT;
            nib_cnt <= '0;
          end else begin
            nib_cnt <= nib_cnt + 1'b1;
          end
        end
        default: state <= ST_HUNT;
      endcase
    end
  end

  // A new error event in the clearing cycle wins over err_clr.
  always_ff @(posedge coreclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      frm_err     <= 1'b0;
      ovf_err     <= 1'b0;
      frm_err_cnt <= '0;
    end else begin
      if (frm_evt) begin
        frm_err     <= 1'b1;
        frm_err_cnt <= err_clr ? 8'd1 :
                       (frm_err_cnt == 8'hFF) ? 8'hFF : frm_err_cnt + 8'd1;
      end else if (err_clr) begin
        frm_err     <= 1'b0;
        frm_err_cnt <= '0;
      end
      if (ovf_evt)      ovf_err <= 1'b1;
      else if (err_clr) ovf_err <= 1'b0;
    end
  end

  fsic_sync_fifo #(
    .pWIDTH (pDATA_WIDTH),
    .pDEPTH (pOUT_DEPTH)
  ) u_out_fifo (
    .clk     (coreclk),
    .rst_n   (axis_rst_n),
    .wr_en   (push_req),
    .wr_data (word_shifted),
    .rd_en   (fifo_pop),
    .rd_data (m_tdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

endmodule

// File: tb/tb_fsic_io_serdes_rx_deframer.sv
// Scoreboard bench for the RX deframer: a frame-level reference model fills
// an expected-word queue, an output monitor compares every presented beat.
module tb_fsic_io_serdes_rx_deframer;

  localparam logic [3:0] SOF  = 4'hA;
  localparam logic [3:0] IDLE = 4'h0;
  localparam int DEPTH = 4;
  localparam int NPW   = 8;

  logic        coreclk = 1'b0;
  logic        axis_rst_n = 1'b1;
  logic        rx_en = 1'b0;
  logic [3:0]  rxdata_in = '0;
  logic        rxdata_in_valid = 1'b0;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        err_clr = 1'b0;
  logic        frm_err;
  logic        ovf_err;
  logic [7:0]  frm_err_cnt;

  fsic_io_serdes_rx_deframer #(
    .pCLK_RATIO  (4),
    .pDATA_WIDTH (32),
    .pOUT_DEPTH  (DEPTH),
    .pSOF        (SOF),
    .pIDLE       (IDLE)
  ) dut (
    .coreclk         (coreclk),
    .axis_rst_n      (axis_rst_n),
    .rx_en           (rx_en),
    .rxdata_in       (rxdata_in),
    .rxdata_in_valid (rxdata_in_valid),
    .m_tdata         (m_tdata),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .err_clr         (err_clr),
    .frm_err         (frm_err),
    .ovf_err         (ovf_err),
    .frm_err_cnt     (frm_err_cnt)
  );

  always #5 coreclk = ~coreclk;

  // Reference model state
  bit          hunting = 1'b1;
  logic [3:0]  nibq[$];
  logic [31:0] exp_q[$];
  int          occ = 0;
  bit          exp_frm = 1'b0;
  bit          exp_ovf = 1'b0;
  int          exp_cnt = 0;

  bit          armed = 1'b0;
  bit          rand_ready = 1'b0;
  logic [31:0] last_word = '0;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Frame-level model: hunt for SOF, collect NPW nibbles, build the word
  // arithmetically, and account FIFO occupancy from the bench's own ready.
  always @(posedge coreclk) begin
    bit pop, fe, oe;
    logic [31:0] w;
    if (axis_rst_n) begin
      pop = m_tready && (occ > 0);
      fe = 1'b0;
      oe = 1'b0;
      if (!rx_en) begin
        hunting = 1'b1;
        nibq.delete();
      end else if (rxdata_in_valid) begin
        if (hunting) begin
          if (rxdata_in == SOF) hunting = 1'b0;
          else if (rxdata_in != IDLE) fe = 1'b1;
        end else begin
          nibq.push_back(rxdata_in);
          if (nibq.size() == NPW) begin
            w = '0;
            foreach (nibq[i]) w = w | (32'(nibq[i]) << (4 * i));
            if (occ < DEPTH || pop) begin
              exp_q.push_back(w);
              occ++;
            end else begin
              oe = 1'b1;
            end
            nibq.delete();
            hunting = 1'b1;
          end
        end
      end
      if (pop) occ--;
      if (fe) begin
        exp_frm = 1'b1;
        exp_cnt = err_clr ? 1 : ((exp_cnt == 255) ? 255 : exp_cnt + 1);
      end else if (err_clr) begin
        exp_frm = 1'b0;
        exp_cnt = 0;
      end
      if (oe) exp_ovf = 1'b1;
      else if (err_clr) exp_ovf = 1'b0;
    end
  end

  // Output monitor on the falling edge
  always @(negedge coreclk) begin
    if (armed) begin
      check("tvalid", 32'(m_tvalid), 32'(occ > 0));
      check("frm_err", 32'(frm_err), 32'(exp_frm));
      check("ovf_err", 32'(ovf_err), 32'(exp_ovf));
      check("frm_err_cnt", 32'(frm_err_cnt), 32'(exp_cnt));
      if (m_tvalid) begin
        if (exp_q.size() == 0) begin
          check("tdata_unexpected", 32'(1), 32'(0));
        end else begin
          check("tdata", m_tdata, exp_q[0]);
          if (m_tready) begin
            last_word = m_tdata;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic drive(input logic [3:0] nib, input logic vld, input logic en, input logic clr);
    rxdata_in       = nib;
    rxdata_in_valid = vld;
    rx_en           = en;
    err_clr         = clr;
    if (rand_ready) m_tready = ($urandom_range(0, 99) < 70);
    @(posedge coreclk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(IDLE, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic send_frame(input logic [31:0] w, input int pause_pct);
    drive(SOF, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < NPW; i++) begin
      while (pause_pct > 0 && $urandom_range(0, 99) < pause_pct)
        drive(4'($urandom), 1'b0, 1'b1, 1'b0);
      drive(w[4*i +: 4], 1'b1, 1'b1, 1'b0);
    end
  endtask

  task automatic do_reset();
    axis_rst_n = 1'b0;
    hunting = 1'b1;
    nibq.delete();
    exp_q.delete();
    occ = 0;
    exp_frm = 1'b0;
    exp_ovf = 1'b0;
    exp_cnt = 0;
    armed = 1'b1;
    #1;
    check("rst_tvalid", 32'(m_tvalid), 32'(0));
    check("rst_tdata", m_tdata, 32'h0);
    check("rst_frm_err", 32'(frm_err), 32'(0));
    check("rst_ovf_err", 32'(ovf_err), 32'(0));
    check("rst_frm_err_cnt", 32'(frm_err_cnt), 32'(0));
    repeat (2) @(posedge coreclk);
    #1;
    axis_rst_n = 1'b1;
  endtask

  task automatic drain(input int max_cycles);
    int t;
    t = 0;
    rand_ready = 1'b0;
    m_tready = 1'b1;
    while (m_tvalid && t < max_cycles) begin
      idle(1);
      t++;
    end
    check("drain_done", 32'(m_tvalid), 32'(0));
  endtask

  initial begin
    logic [31:0] w;
    logic [3:0]  n;
    int          r;
    int          k;

    #1;
    do_reset();

    // Reset and idle
    idle(20);
    check("idle_tvalid", 32'(m_tvalid), 32'(0));
    check("idle_frm_err", 32'(frm_err), 32'(0));

    // Single frame, one-cycle latency
    m_tready = 1'b1;
    send_frame(32'h1234_5678, 0);
    check("single_tvalid", 32'(m_tvalid), 32'(1));
    check("single_tdata", m_tdata, 32'h1234_5678);
    idle(3);
    check("single_popped", last_word, 32'h1234_5678);

    // Back-to-back frames with stalled output
    m_tready = 1'b0;
    for (int f = 0; f < 6; f++) begin
      send_frame($urandom, 0);
      if (f == 3) check("stall_no_ovf_yet", 32'(ovf_err), 32'(0));
      if (f == 4) check("stall_ovf_set", 32'(ovf_err), 32'(1));
    end
    drain(20);
    drive(IDLE, 1'b1, 1'b1, 1'b1);
    check("ovf_cleared", 32'(ovf_err), 32'(0));

    // Framing error, capture after error, clear, set-wins-over-clear
    m_tready = 1'b1;
    drive(4'h3, 1'b1, 1'b1, 1'b0);
    check("frm_err_set", 32'(frm_err), 32'(1));
    check("frm_err_cnt1", 32'(frm_err_cnt), 32'(1));
    send_frame(32'hCAFE_A0A5, 0);
    idle(2);
    check("after_err_word", last_word, 32'hCAFE_A0A5);
    drive(4'h7, 1'b1, 1'b1, 1'b0);
    drive(4'h5, 1'b1, 1'b1, 1'b1);
    check("clr_set_wins_cnt", 32'(frm_err_cnt), 32'(1));
    drive(IDLE, 1'b1, 1'b1, 1'b1);
    check("clr_frm_err", 32'(frm_err), 32'(0));
    check("clr_cnt", 32'(frm_err_cnt), 32'(0));

    // Counter saturation
    repeat (260) drive(4'h5, 1'b1, 1'b1, 1'b0);
    check("cnt_saturated", 32'(frm_err_cnt), 32'(255));
    drive(IDLE, 1'b1, 1'b1, 1'b1);

    // Flush mid-frame via rx_en
    drive(SOF, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(4'($urandom), 1'b1, 1'b1, 1'b0);
    drive(4'h3, 1'b1, 1'b0, 1'b0);
    drive(4'h3, 1'b1, 1'b0, 1'b0);
    send_frame(32'h0BAD_F00D, 0);
    idle(2);
    check("flush_word", last_word, 32'h0BAD_F00D);
    check("flush_no_err", 32'(frm_err), 32'(0));

    // Valid pause mid-frame
    w = 32'h9876_ABCD;
    drive(SOF, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < NPW; i++) begin
      if (i == 3) repeat (3) drive(SOF, 1'b0, 1'b1, 1'b0);
      drive(w[4*i +: 4], 1'b1, 1'b1, 1'b0);
    end
    idle(2);
    check("pause_word", last_word, 32'h9876_ABCD);

    // Async reset mid-frame with a word held in the FIFO
    m_tready = 1'b0;
    send_frame($urandom, 0);
    drive(SOF, 1'b1, 1'b1, 1'b0);
    drive(4'h1, 1'b1, 1'b1, 1'b0);
    drive(4'h2, 1'b1, 1'b1, 1'b0);
    do_reset();
    m_tready = 1'b1;
    send_frame(32'h5555_AAAA, 0);
    idle(2);
    check("post_reset_word", last_word, 32'h5555_AAAA);

    // Randomized traffic
    rand_ready = 1'b1;
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        send_frame($urandom, ($urandom_range(0, 3) == 0) ? 20 : 0);
      end else if (r < 68) begin
        idle($urandom_range(1, 4));
      end else if (r < 78) begin
        n = 4'($urandom_range(1, 15));
        if (n == SOF) n = 4'h5;
        drive(n, 1'b1, 1'b1, 1'b0);
      end else if (r < 88) begin
        drive(SOF, 1'b1, 1'b1, 1'b0);
        k = $urandom_range(0, NPW - 1);
        for (int i = 0; i < k; i++) drive(4'($urandom), 1'b1, 1'b1, 1'b0);
        drive(4'($urandom), 1'($urandom), 1'b0, 1'b0);
      end else begin
        drive(4'($urandom), 1'b1, 1'b1, 1'b1);
      end
    end
    drain(50);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
